// File: rtl/cam_capture_scaler_pkg.sv
// Shared encodings for the OV7670 capture/scaler: output formats, FSM states,
// RGB565 field positions and (with CAM_CAPTURE_TEST_PATTERN_EN) the colour-bar table.
package cam_capture_scaler_pkg;

    localparam int FMT_RGB332 = 0;
    localparam int FMT_RGB444 = 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_VBLANK = 2'd1,
        S_ACTIVE = 2'd2
    } state_t;

    localparam int R_MSB = 15;
    localparam int R_LSB = 11;
    localparam int G_MSB = 10;
    localparam int G_LSB = 5;
    localparam int B_MSB = 4;
    localparam int B_LSB = 0;

    function automatic int fmt_width(input int fmt);
        return (fmt == FMT_RGB444) ? 12 : 8;
    endfunction

`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    // Left to right: white, yellow, cyan, green, magenta, red, blue, black (RGB565).
    localparam logic [15:0] COLOR_BAR [8] = '{
        16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
        16'hF81F, 16'hF800, 16'h001F, 16'h0000
    };
`endif

endpackage

// File: rtl/cam_capture_scaler_if.sv
// Frame-buffer write port: address, data and a one-cycle write strobe.
interface cam_capture_scaler_if #(
    parameter int AW = 15,
    parameter int DW = 8
);
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          mem_we;

    modport master (output mem_addr, output mem_data, output mem_we);
    modport slave  (input  mem_addr, input  mem_data, input  mem_we);
endinterface

// File: rtl/cam_pixel_convert.sv
// Combinational RGB565 -> RGB332/RGB444 converter; with CAM_CAPTURE_TEST_PATTERN_EN
// a colour-bar source can replace the camera pixel before conversion.
module cam_pixel_convert
    import cam_capture_scaler_pkg::*;
#(
    parameter int OUT_FMT = FMT_RGB332,
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    parameter int CAM_X   = 160,
    parameter int XW      = 8,
`endif
    parameter int DW      = 8
) (
    input  logic [15:0]   pix_in,
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    input  logic          pattern_sel,
    input  logic [XW-1:0] wr_x,
`endif
    output logic [DW-1:0] pix_out
);

    logic [15:0] src;
    logic [4:0]  r;
    logic [5:0]  g;
    logic [4:0]  b;

`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    logic [2:0] band;
    assign band = 3'((int'(wr_x) * 8) / CAM_X);
    assign src  = pattern_sel ? COLOR_BAR[band] : pix_in;
`else
    assign src  = pix_in;
`endif

    assign r = src[R_MSB:R_LSB];
    assign g = src[G_MSB:G_LSB];
    assign b = src[B_MSB:B_LSB];

    if (OUT_FMT == FMT_RGB444) begin : g_rgb444
        logic unused_lsbs;
        assign unused_lsbs = ^{r[0], g[1:0], b[0]};
        assign pix_out     = {r[4:1], g[5:2], b[4:1]};
    end else begin : g_rgb332
        logic unused_lsbs;
        assign unused_lsbs = ^{r[1:0], g[2:0], b[2:0]};
        assign pix_out     = {r[4:2], g[5:3], b[4:3]};
    end

endmodule

// File: rtl/cam_capture_scaler.sv
// OV7670 capture front-end: byte pairing, DEC_X/DEC_Y decimation, format conversion
// and frame-buffer writes. Optional colour bars via CAM_CAPTURE_TEST_PATTERN_EN.
module cam_capture_scaler
    import cam_capture_scaler_pkg::*;
#(
    parameter int CAM_X   = 160,
    parameter int CAM_Y   = 120,
    parameter int DEC_X   = 4,
    parameter int DEC_Y   = 4,
    parameter int AW      = 15,
    parameter int OUT_FMT = FMT_RGB332,
    parameter int DW      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       capture_en,
    input  logic       vsync,
    input  logic       href,
    input  logic [7:0] data,
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
    input  logic       pattern_sel,
`endif
    cam_capture_scaler_if.master mem,
    output logic       frame_done,
    output logic [7:0] frame_cnt,
    output logic       overflow,
    output logic       busy
);

    if (DW != fmt_width(OUT_FMT) || (OUT_FMT != FMT_RGB332 && OUT_FMT != FMT_RGB444)) begin : g_bad_fmt
        $error("cam_capture_scaler: DW must be 8 for RGB332 and 12 for RGB444");
    end
    if ((1 << AW) <= CAM_X * CAM_Y) begin : g_bad_aw
        $error("cam_capture_scaler: AW too small for CAM_X*CAM_Y");
    end
    if (DEC_X < 1 || DEC_X > 8 || (DEC_X & (DEC_X - 1)) != 0 ||
        DEC_Y < 1 || DEC_Y > 8 || (DEC_Y & (DEC_Y - 1)) != 0) begin : g_bad_dec
        $error("cam_capture_scaler: DEC_X/DEC_Y must be powers of two in 1..8");
    end

    localparam int             XW         = $clog2(CAM_X + 1);
    localparam int             YW         = $clog2(CAM_Y + 1);
    localparam logic [XW-1:0]  CAM_X_W    = XW'(CAM_X);
    localparam logic [YW-1:0]  CAM_Y_W    = YW'(CAM_Y);
    localparam logic [AW-1:0]  LINE_STEP  = AW'(CAM_X);
    localparam logic [7:0]     DEC_X_MASK = 8'(DEC_X - 1);
    localparam logic [7:0]     DEC_Y_MASK = 8'(DEC_Y - 1);

    // Registered camera inputs and their previous values for edge detection.
    logic       vsync_q, href_q, vsync_prev_q, href_prev_q;
    logic [7:0] data_q;

    state_t        state_q, state_d;
    logic          phase_q, phase_d;
    logic [7:0]    hi_q, hi_d;
    logic [7:0]    src_x_q, src_x_d, src_y_q, src_y_d;
    logic [XW-1:0] wr_x_q, wr_x_d;
    logic [YW-1:0] wr_y_q, wr_y_d;
    logic [AW-1:0] line_base_q, line_base_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_data_q, mem_data_d;
    logic          mem_we_q, mem_we_d;
    logic          frame_done_q, frame_done_d;
    logic [7:0]    frame_cnt_q, frame_cnt_d;
    logic          overflow_q, overflow_d;

    logic          vsync_rise, vsync_fall, href_fall;
    logic          line_kept, keep_pix;
    logic [DW-1:0] pix_conv;

    assign vsync_rise = vsync_q & ~vsync_prev_q;
    assign vsync_fall = ~vsync_q & vsync_prev_q;
    assign href_fall  = ~href_q & href_prev_q;
    assign line_kept  = (src_y_q & DEC_Y_MASK) == 8'd0;
    assign keep_pix   = line_kept && ((src_x_q & DEC_X_MASK) == 8'd0);

    cam_pixel_convert #(
        .OUT_FMT    (OUT_FMT),
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
        .CAM_X      (CAM_X),
        .XW         (XW),
`endif
        .DW         (DW)
    ) u_convert (
        .pix_in     ({hi_q, data_q}),
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
        .pattern_sel(pattern_sel),
        .wr_x       (wr_x_q),
`endif
        .pix_out    (pix_conv)
    );

    always_comb begin
        // NOTE: every _d takes its hold value first, so no path through this block infers a latch.
        state_d      = state_q;
        phase_d      = phase_q;
        hi_d         = hi_q;
        src_x_d      = src_x_q;
        src_y_d      = src_y_q;
        wr_x_d       = wr_x_q;
        wr_y_d       = wr_y_q;
        line_base_d  = line_base_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        mem_we_d     = 1'b0;
        frame_done_d = 1'b0;
        frame_cnt_d  = frame_cnt_q;
        overflow_d   = overflow_q;

        unique case (state_q)
            S_IDLE: begin
                if (capture_en && vsync_q) state_d = S_VBLANK;
            end
            S_VBLANK: begin
                src_x_d     = '0;
                src_y_d     = '0;
                wr_x_d      = '0;
                wr_y_d      = '0;
                line_base_d = '0;
                mem_addr_d  = '0;
                overflow_d  = 1'b0;
                phase_d     = 1'b0;
                if (vsync_fall) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                if (href_q) begin
                    if (!phase_q) begin
                        hi_d    = data_q;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        src_x_d = src_x_q + 8'd1;
                        if (keep_pix) begin
                            if (wr_x_q < CAM_X_W && wr_y_q < CAM_Y_W) begin
                                mem_we_d   = 1'b1;
                                mem_addr_d = line_base_q + AW'(wr_x_q);
                                mem_data_d = pix_conv;
                                wr_x_d     = wr_x_q + XW'(1);
                            end else begin
                                overflow_d = 1'b1;
                            end
                        end
                    end
                end
                // Line end drops any odd trailing byte; kept lines advance the aligned base.
                if (href_fall) begin
                    phase_d = 1'b0;
                    src_x_d = '0;
                    wr_x_d  = '0;
                    src_y_d = src_y_q + 8'd1;
                    if (line_kept && wr_y_q < CAM_Y_W) begin
                        wr_y_d      = wr_y_q + YW'(1);
                        line_base_d = line_base_q + LINE_STEP;
                    end
                end
                if (vsync_rise) begin
                    frame_done_d = 1'b1;
                    frame_cnt_d  = frame_cnt_q + 8'd1;
                    state_d      = capture_en ? S_VBLANK : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vsync_q      <= 1'b0;
            href_q       <= 1'b0;
            data_q       <= '0;
            vsync_prev_q <= 1'b0;
            href_prev_q  <= 1'b0;
            state_q      <= S_IDLE;
            phase_q      <= 1'b0;
            hi_q         <= '0;
            src_x_q      <= '0;
            src_y_q      <= '0;
            wr_x_q       <= '0;
            wr_y_q       <= '0;
            line_base_q  <= '0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            mem_we_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
            overflow_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, independent of statement order.
            vsync_q      <= vsync;
            href_q       <= href;
            data_q       <= data;
            vsync_prev_q <= vsync_q;
            href_prev_q  <= href_q;
            state_q      <= state_d;
            phase_q      <= phase_d;
            hi_q         <= hi_d;
            src_x_q      <= src_x_d;
            src_y_q      <= src_y_d;
            wr_x_q       <= wr_x_d;
            wr_y_q       <= wr_y_d;
            line_base_q  <= line_base_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            mem_we_q     <= mem_we_d;
            frame_done_q <= frame_done_d;
            frame_cnt_q  <= frame_cnt_d;
            overflow_q   <= overflow_d;
        end
    end

    assign mem.mem_addr = mem_addr_q;
    assign mem.mem_data = mem_data_q;
    assign mem.mem_we   = mem_we_q;
    assign frame_done   = frame_done_q;
    assign frame_cnt    = frame_cnt_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q == S_ACTIVE);

endmodule

// File: tb/tb_cam_capture_scaler.sv
// Directed bench for cam_capture_scaler: an RGB332 and an RGB444 instance share
// the camera stimulus; writes are logged on the falling clock edge.
module tb_cam_capture_scaler;

    localparam int AW = 15;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       capture_en = 1'b0;
    logic       vsync = 1'b0;
    logic       href = 1'b0;
    logic [7:0] data = 8'h00;

    logic       fd0, fd1, ov0, ov1, busy0, busy1;
    logic [7:0] fc0, fc1;

    int pass_cnt = 0;
    int total_cnt = 0;
    int fd0_count = 0;
    int fd1_count = 0;
    int frames_expected = 0;

    logic [AW-1:0] log0_addr[$];
    logic [7:0]    log0_data[$];
    logic [11:0]   log1_data[$];

    typedef struct {
        logic [15:0] pix;
        logic [7:0]  e332;
        logic [11:0] e444;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    cam_capture_scaler_if #(.AW(AW), .DW(8))  m0 ();
    cam_capture_scaler_if #(.AW(AW), .DW(12)) m1 ();

    cam_capture_scaler #(.OUT_FMT(0), .DW(8)) dut0 (
        .clk(clk), .rst(rst), .capture_en(capture_en),
        .vsync(vsync), .href(href), .data(data),
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
        .pattern_sel(1'b0),
`endif
        .mem(m0), .frame_done(fd0), .frame_cnt(fc0), .overflow(ov0), .busy(busy0)
    );

    cam_capture_scaler #(.OUT_FMT(1), .DW(12)) dut1 (
        .clk(clk), .rst(rst), .capture_en(capture_en),
        .vsync(vsync), .href(href), .data(data),
`ifdef CAM_CAPTURE_TEST_PATTERN_EN
        .pattern_sel(1'b0),
`endif
        .mem(m1), .frame_done(fd1), .frame_cnt(fc1), .overflow(ov1), .busy(busy1)
    );

    always @(negedge clk) begin
        if (m0.mem_we) begin
            log0_addr.push_back(m0.mem_addr);
            log0_data.push_back(m0.mem_data);
        end
        if (m1.mem_we) log1_data.push_back(m1.mem_data);
        if (fd0) fd0_count++;
        if (fd1) fd1_count++;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    function automatic logic [15:0] pix_val(input int line, input int x);
        return 16'(line * 4096 + x * 37) ^ 16'h5A3C;
    endfunction

    function automatic logic [7:0] conv332(input logic [15:0] p);
        return {p[15:13], p[10:8], p[4:3]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pixel(input logic [15:0] p);
        href = 1'b1;
        data = p[15:8];
        tick();
        data = p[7:0];
        tick();
    endtask

    task automatic end_line();
        href = 1'b0;
        data = 8'h00;
        repeat (4) tick();
    endtask

    task automatic send_line(input int line, input int npix);
        for (int x = 0; x < npix; x++) send_pixel(pix_val(line, x));
        end_line();
    endtask

    task automatic start_frame();
        vsync = 1'b1;
        repeat (4) tick();
        vsync = 1'b0;
        repeat (4) tick();
    endtask

    task automatic end_frame();
        vsync = 1'b1;
        repeat (4) tick();
        frames_expected++;
    endtask

    initial begin
        int base;
        int errs;
        int fd_base;
        int nwrap;

        vecs[0] = '{16'hF800, 8'hE0, 12'hF00};
        vecs[1] = '{16'h07E0, 8'h1C, 12'h0F0};
        vecs[2] = '{16'h001F, 8'h03, 12'h00F};
        vecs[3] = '{16'hFFFF, 8'hFF, 12'hFFF};
        vecs[4] = '{16'h1234, 8'h0A, 12'h14A};
        vecs[5] = '{16'hA5C3, 8'hB4, 12'hAB1};

        // Reset values
        #1;
        check("reset mem_we", {31'd0, m0.mem_we}, 0);
        check("reset mem_addr", 32'(m0.mem_addr), 0);
        check("reset frame_cnt", 32'(fc0), 0);
        check("reset busy", {31'd0, busy0}, 0);
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Asynchronous reset in the middle of a captured frame
        capture_en = 1'b1;
        start_frame();
        send_line(0, 16);
        href = 1'b1;
        for (int i = 0; i < 6; i++) begin
            data = 8'h3C;
            tick();
        end
        check("busy before reset", {31'd0, busy0}, 1);
        check("addr before reset", 32'(m0.mem_addr), 3);
        #2 rst = 1'b0;
        #1;
        check("async reset mem_addr", 32'(m0.mem_addr), 0);
        check("async reset mem_data", 32'(m0.mem_data), 0);
        check("async reset mem_we", {31'd0, m0.mem_we}, 0);
        check("async reset frame_done", {31'd0, fd0}, 0);
        check("async reset frame_cnt", 32'(fc0), 0);
        check("async reset overflow", {31'd0, ov0}, 0);
        check("async reset busy", {31'd0, busy0}, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        base = log0_addr.size();
        repeat (4) tick();
        end_line();
        send_line(1, 16);
        send_line(2, 16);
        check("no capture of frame in progress", 32'(log0_addr.size() - base), 0);

        // Full frame: 8 lines of 640 pixels, 4x4 decimation
        fd_base = fd0_count;
        base = log0_addr.size();
        start_frame();
        for (int l = 0; l < 8; l++) send_line(l, 640);
        capture_en = 1'b0;
        end_frame();
        check("frame write count", 32'(log0_addr.size() - base), 320);
        errs = 0;
        for (int j = 0; j < 320; j++) begin
            int line;
            line = (j < 160) ? 0 : 4;
            if (log0_addr[base + j] !== AW'(j)) errs++;
            if (log0_data[base + j] !== conv332(pix_val(line, 4 * (j % 160)))) errs++;
        end
        check("frame addr/data errors", 32'(errs), 0);
        check("frame write 160 addr", 32'(log0_addr[base + 160]), 160);
        check("frame_done pulses", 32'(fd0_count - fd_base), 1);
        check("frame_cnt after frame", 32'(fc0), 1);
        check("busy after disabled frame end", {31'd0, busy0}, 0);
        check("busy1 after disabled frame end", {31'd0, busy1}, 0);

        // Enable raised mid-frame: nothing written until a full vsync high->low
        vsync = 1'b0;
        repeat (4) tick();
        check("idle after vsync fall", {31'd0, busy0}, 0);
        base = log0_addr.size();
        send_line(0, 16);
        href = 1'b1;
        for (int i = 0; i < 10; i++) begin
            data = 8'(i);
            if (i == 5) capture_en = 1'b1;
            tick();
        end
        end_line();
        send_line(1, 16);
        send_line(2, 16);
        check("no writes before sync", 32'(log0_addr.size() - base), 0);
        check("idle before sync", {31'd0, busy0}, 0);
        start_frame();
        send_pixel(16'hF800);
        href = 1'b0;
        @(negedge clk);
        check("latency: no strobe yet", {31'd0, m0.mem_we}, 0);
        @(negedge clk);
        check("latency: strobe", {31'd0, m0.mem_we}, 1);
        check("first addr", 32'(m0.mem_addr), 0);
        check("F800 as RGB332", 32'(m0.mem_data), 32'hE0);
        check("F800 as RGB444", 32'(m1.mem_data), 32'hF00);
        @(negedge clk);
        check("strobe one cycle", {31'd0, m0.mem_we}, 0);
        repeat (3) tick();
        end_frame();
        check("writes after sync", 32'(log0_addr.size() - base), 1);

        // Conversion table
        base = log0_addr.size();
        start_frame();
        for (int k = 0; k < 6; k++) begin
            send_pixel(vecs[k].pix);
            repeat (3) send_pixel(16'h5555);
        end
        end_line();
        end_frame();
        check("table write count", 32'(log0_addr.size() - base), 6);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("vec%0d addr", k), 32'(log0_addr[base + k]), k);
            check($sformatf("vec%0d rgb332", k), 32'(log0_data[base + k]), 32'(vecs[k].e332));
            check($sformatf("vec%0d rgb444", k), 32'(log1_data[base + k]), 32'(vecs[k].e444));
        end

        // Over-wide line: 700 pixels -> 175 kept, 160 written, overflow
        base = log0_addr.size();
        start_frame();
        send_line(0, 700);
        check("overflow on wide line", {31'd0, ov0}, 1);
        check("overflow rgb444 dut", {31'd0, ov1}, 1);
        check("wide line write count", 32'(log0_addr.size() - base), 160);
        check("wide line last addr", 32'(log0_addr[base + 159]), 159);
        end_frame();

        // Short kept line, odd-length kept line, then a pairing check
        base = log0_addr.size();
        start_frame();
        check("overflow cleared next frame", {31'd0, ov0}, 0);
        send_line(0, 100);
        for (int l = 1; l < 4; l++) send_line(l, 10);
        for (int x = 0; x < 640; x++) send_pixel(pix_val(4, x));
        href = 1'b1;
        data = 8'hAB;
        tick();
        end_line();
        check("no overflow 640px line", {31'd0, ov0}, 0);
        for (int l = 5; l < 8; l++) send_line(l, 10);
        send_pixel(16'h07E0);
        repeat (3) send_pixel(16'h5555);
        end_line();
        end_frame();
        check("short/odd frame write count", 32'(log0_addr.size() - base), 186);
        check("line after short line addr", 32'(log0_addr[base + 25]), 160);
        check("odd line last data", 32'(log0_data[base + 184]), 32'(conv332(pix_val(4, 636))));
        check("after odd line addr", 32'(log0_addr[base + 185]), 320);
        check("after odd line pairing", 32'(log0_data[base + 185]), 32'h1C);
        check("frame_cnt before wrap", 32'(fc0), frames_expected);

        // frame_cnt wrap: empty frames until 256 captured frames
        fd_base = fd1_count;
        nwrap = 256 - frames_expected;
        for (int f = 0; f < nwrap; f++) begin
            if (f == nwrap - 1) check("frame_cnt at 255", 32'(fc0), 255);
            vsync = 1'b0;
            repeat (3) tick();
            vsync = 1'b1;
            repeat (3) tick();
        end
        check("frame_cnt wrapped", 32'(fc0), 0);
        check("frame_cnt wrapped rgb444 dut", 32'(fc1), 0);
        check("frame_done pulses in wrap", 32'(fd1_count - fd_base), 32'(nwrap));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
